// File: rtl/multicycle_control.sv
// Multicycle datapath controller (classic MIPS-style FSM).
// Sequences fetch/decode/execute for lw, sw, R-type, beq and j.
// Control outputs are decoded from the state. The FETCH write enables follow
// i_mem_ready. The block also counts retired instructions and pulses
// o_illegal for one cycle when DECODE sees an unsupported opcode.
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_enable             allows the FSM to leave RESET
//   i_opcode             instruction opcode field
//   i_mem_ready          memory access complete
//   o_alu_op .. o_reg_dst  datapath control signals
//   o_state              current state encoding
//   o_illegal            one-cycle pulse on unsupported opcode
//   o_inst_count         retired instruction counter (wraps)
module multicycle_control #(
  parameter int NB_OPCODE = 6,
  parameter int NB_ALU_OP = 2,
  parameter int NB_STATE  = 4,
  parameter int NB_COUNT  = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_enable,
  input  logic [NB_OPCODE-1:0] i_opcode,
  input  logic                 i_mem_ready,
  output logic [NB_ALU_OP-1:0] o_alu_op,
  output logic                 o_alu_src_a,
  output logic [1:0]           o_alu_src_b,
  output logic                 o_pc_write,
  output logic                 o_pc_write_cond,
  output logic [1:0]           o_pc_source,
  output logic                 o_i_or_d,
  output logic                 o_mem_read,
  output logic                 o_mem_write,
  output logic                 o_ir_write,
  output logic                 o_mem_to_reg,
  output logic                 o_reg_write,
  output logic                 o_reg_dst,
  output logic [NB_STATE-1:0]  o_state,
  output logic                 o_illegal,
  output logic [NB_COUNT-1:0]  o_inst_count
);

  typedef enum logic [NB_STATE-1:0] {
    ST_RESET  = NB_STATE'(0),
    ST_FETCH  = NB_STATE'(1),
    ST_DECODE = NB_STATE'(2),
    ST_MEMADR = NB_STATE'(3),
    ST_MEMRD  = NB_STATE'(4),
    ST_MEMWB  = NB_STATE'(5),
    ST_MEMWR  = NB_STATE'(6),
    ST_EXEC   = NB_STATE'(7),
    ST_ALUWB  = NB_STATE'(8),
    ST_BRANCH = NB_STATE'(9),
    ST_JUMP   = NB_STATE'(10)
  } state_t;

  localparam logic [NB_OPCODE-1:0] OP_LW    = NB_OPCODE'(6'b100011);
  localparam logic [NB_OPCODE-1:0] OP_SW    = NB_OPCODE'(6'b101011);
  localparam logic [NB_OPCODE-1:0] OP_RTYPE = NB_OPCODE'(6'b000000);
  localparam logic [NB_OPCODE-1:0] OP_BEQ   = NB_OPCODE'(6'b000100);
  localparam logic [NB_OPCODE-1:0] OP_J     = NB_OPCODE'(6'b000010);

  state_t state, state_next;
  logic   illegal_next;
  logic   retire;

  // State register plus the two side registers (illegal pulse, counter)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_RESET;
      o_illegal    <= 1'b0;
      o_inst_count <= '0;
    end else begin
      state     <= state_next;
      o_illegal <= illegal_next;
      if (retire) o_inst_count <= o_inst_count + NB_COUNT'(1);
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_RESET:  if (i_enable) state_next = ST_FETCH;
      ST_FETCH:  if (i_mem_ready) state_next = ST_DECODE;
      ST_DECODE: begin
        case (i_opcode)
          OP_LW, OP_SW: state_next = ST_MEMADR;
          OP_RTYPE:     state_next = ST_EXEC;
          OP_BEQ:       state_next = ST_BRANCH;
          OP_J:         state_next = ST_JUMP;
          default:      state_next = ST_FETCH;
        endcase
      end
      // lw/sw split is taken on the opcode seen here, not the DECODE one
      ST_MEMADR: begin
        if (i_opcode == OP_LW)      state_next = ST_MEMRD;
        else if (i_opcode == OP_SW) state_next = ST_MEMWR;
        else                        state_next = ST_FETCH;
      end
      ST_MEMRD:  if (i_mem_ready) state_next = ST_MEMWB;
      ST_MEMWR:  if (i_mem_ready) state_next = ST_FETCH;
      ST_EXEC:   state_next = ST_ALUWB;
      ST_MEMWB, ST_ALUWB, ST_BRANCH, ST_JUMP: state_next = ST_FETCH;
      default:   state_next = ST_FETCH;
    endcase
  end

  // Retire: final state of a completed instruction returning to FETCH
  always_comb begin
    retire       = 1'b0;
    illegal_next = 1'b0;
    case (state)
      ST_MEMWB, ST_ALUWB, ST_BRANCH, ST_JUMP: retire = 1'b1;
      ST_MEMWR: retire = i_mem_ready;
      ST_DECODE: illegal_next = !(i_opcode inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J});
      default: ;
    endcase
  end

  // Output decode
  always_comb begin
    o_alu_op        = '0;
    o_alu_src_a     = 1'b0;
    o_alu_src_b     = 2'b00;
    o_pc_write      = 1'b0;
    o_pc_write_cond = 1'b0;
    o_pc_source     = 2'b00;
    o_i_or_d        = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_ir_write      = 1'b0;
    o_mem_to_reg    = 1'b0;
    o_reg_write     = 1'b0;
    o_reg_dst       = 1'b0;
    case (state)
      ST_FETCH: begin
        o_mem_read  = 1'b1;
        o_alu_src_b = 2'b01;
        o_ir_write  = i_mem_ready;
        o_pc_write  = i_mem_ready;
      end
      ST_DECODE: o_alu_src_b = 2'b11;
      ST_MEMADR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
      end
      ST_MEMRD: begin
        o_mem_read = 1'b1;
        o_i_or_d   = 1'b1;
      end
      ST_MEMWB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 1'b1;
      end
      ST_MEMWR: begin
        o_mem_write = 1'b1;
        o_i_or_d    = 1'b1;
      end
      ST_EXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = NB_ALU_OP'(2'b10);
      end
      ST_ALUWB: begin
        o_reg_write = 1'b1;
        o_reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        o_alu_src_a     = 1'b1;
        o_alu_op        = NB_ALU_OP'(2'b01);
        o_pc_write_cond = 1'b1;
        o_pc_source     = 2'b01;
      end
      ST_JUMP: begin
        o_pc_write  = 1'b1;
        o_pc_source = 2'b10;
      end
      default: ;
    endcase
  end

  assign o_state = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. The counter is built 4 bits wide
// so that wrap-around is reachable. The reference model works per
// instruction: each opcode maps to a list of states to visit. FETCH, MEMRD
// and MEMWR wait for i_mem_ready. Expected controls come from a per-state
// table.
module tb_multicycle_control;

  localparam int CNT_W = 4;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  logic             clk = 1'b0;
  logic             rst_n, enable, mem_ready;
  logic [5:0]       opcode;
  logic [1:0]       alu_op, alu_src_b, pc_source;
  logic             alu_src_a, pc_write, pc_write_cond, i_or_d, mem_read;
  logic             mem_write, ir_write, mem_to_reg, reg_write, reg_dst;
  logic [3:0]       state;
  logic             illegal;
  logic [CNT_W-1:0] inst_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  logic             exp_ill = 1'b0;

  always #5 clk = ~clk;

  multicycle_control #(.NB_OPCODE(6), .NB_ALU_OP(2), .NB_STATE(4), .NB_COUNT(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_opcode(opcode),
    .i_mem_ready(mem_ready), .o_alu_op(alu_op), .o_alu_src_a(alu_src_a),
    .o_alu_src_b(alu_src_b), .o_pc_write(pc_write), .o_pc_write_cond(pc_write_cond),
    .o_pc_source(pc_source), .o_i_or_d(i_or_d), .o_mem_read(mem_read),
    .o_mem_write(mem_write), .o_ir_write(ir_write), .o_mem_to_reg(mem_to_reg),
    .o_reg_write(reg_write), .o_reg_dst(reg_dst), .o_state(state),
    .o_illegal(illegal), .o_inst_count(inst_count)
  );

  // {alu_op, src_a, src_b, pc_write, pc_write_cond, pc_source,
  //  i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write, reg_dst}
  logic [15:0] act_ctrl;
  assign act_ctrl = {alu_op, alu_src_a, alu_src_b, pc_write, pc_write_cond, pc_source,
                     i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write, reg_dst};

  function automatic logic [15:0] exp_ctrl(input int st, input logic rdy);
    case (st)
      1:  return {2'b00, 1'b0, 2'b01, rdy, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, rdy, 3'b000};
      2:  return {2'b00, 1'b0, 2'b11, 11'b0};
      3:  return {2'b00, 1'b1, 2'b10, 11'b0};
      4:  return {9'b0, 7'b1100000};
      5:  return {9'b0, 7'b0000110};
      6:  return {9'b0, 7'b1010000};
      7:  return {2'b10, 1'b1, 2'b00, 11'b0};
      8:  return {9'b0, 7'b0000011};
      9:  return {2'b01, 1'b1, 2'b00, 1'b0, 1'b1, 2'b01, 7'b0};
      10: return {5'b0, 1'b1, 1'b0, 2'b10, 7'b0};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_cycle(input int st, input logic rdy);
    check("state", 32'(state), st);
    check("ctrl", 32'(act_ctrl), 32'(exp_ctrl(st, rdy)));
    check("illegal", 32'(illegal), 32'(exp_ill));
    check("count", 32'(inst_count), 32'(exp_cnt));
    check("rd_wr_excl", 32'(mem_read & mem_write), 0);
    exp_ill = 1'b0;
  endtask

  // mode 0: always ready; 1: random ready; 2: MEMWR sees ready low 3 times.
  // Starts and ends at a negedge with the DUT in FETCH (unless aborted).
  task automatic run_instr(input logic [5:0] op, input int mode, input int abort_st,
                           output bit aborted);
    int seq[$];
    int k;
    int waits;
    logic rdy;
    aborted = 1'b0;
    case (op)
      OP_LW:   seq = '{1, 2, 3, 4, 5};
      OP_SW:   seq = '{1, 2, 3, 6};
      OP_R:    seq = '{1, 2, 7, 8};
      OP_BEQ:  seq = '{1, 2, 9};
      OP_J:    seq = '{1, 2, 10};
      default: seq = '{1, 2};
    endcase
    opcode = op;
    k = 0;
    waits = 0;
    while (k < seq.size()) begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 3) != 0);
        default: begin
          rdy = !(seq[k] == 6 && waits < 3);
          if (!rdy) waits++;
        end
      endcase
      mem_ready = rdy;
      #1;
      check_cycle(seq[k], rdy);
      if (seq[k] == abort_st) begin
        aborted = 1'b1;
        return;
      end
      if (!(seq[k] inside {1, 4, 6}) || rdy) k++;
      @(negedge clk);
    end
    if (seq.size() == 2) exp_ill = 1'b1;
    else exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic leave_reset();
    enable = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ab;
    logic [5:0] op;
    rst_n = 1'b0; enable = 1'b0; mem_ready = 1'b0; opcode = '0;
    #1;
    check_cycle(0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    // Held in RESET while enable is low
    repeat (3) begin
      @(negedge clk); #1;
      check_cycle(0, 1'b0);
    end
    leave_reset();

    // Directed instructions
    run_instr(OP_LW, 0, -1, ab);
    run_instr(OP_R, 0, -1, ab);
    run_instr(OP_BEQ, 0, -1, ab);
    run_instr(OP_SW, 2, -1, ab);
    run_instr(6'b111111, 0, -1, ab);
    run_instr(OP_J, 0, -1, ab);
    run_instr(OP_J, 1, -1, ab);

    // Asynchronous reset in MEMRD, then hold in RESET with enable low
    run_instr(OP_LW, 0, 4, ab);
    #2 rst_n = 1'b0;
    enable = 1'b0;
    exp_cnt = '0;
    exp_ill = 1'b0;
    #1;
    check_cycle(0, mem_ready);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      check_cycle(0, mem_ready);
    end
    leave_reset();

    // Counter wrap: 16 retirements from zero return to zero
    repeat (16) run_instr(OP_J, 0, -1, ab);
    check("wrap", 32'(inst_count), 0);

    // Randomized instruction stream
    repeat (300) begin
      case ($urandom_range(0, 6))
        0: op = OP_LW;
        1: op = OP_SW;
        2: op = OP_R;
        3: op = OP_BEQ;
        4: op = OP_J;
        5: op = 6'($urandom);
        default: op = 6'b111111;
      endcase
      run_instr(op, 1, -1, ab);
    end
    mem_ready = 1'b0;
    #1;
    check_cycle(1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter NB_OPCODE, default 6, SHALL set the opcode field width.
REQ-002 Parameter NB_ALU_OP, default 2, SHALL set the ALU-operation class width sent to the ALU decoder.
REQ-003 Parameter NB_STATE, default 4, SHALL set the state register width.
REQ-004 Parameter NB_COUNT, default 32, SHALL set the retired-instruction counter width.
REQ-005 Ports SHALL be as listed below, clock and reset first:
 i_clk  in  1  single clock; all state changes on rising edge
 i_rst_n  in  1  asynchronous, active-low reset
 i_enable  in  1  permits leaving RESET
 i_opcode  in  NB_OPCODE  opcode field of the instruction register
 i_mem_ready  in  1  memory has completed the current access
 o_alu_op  out  NB_ALU_OP  00 add (address/PC), 01 subtract (branch), 10 R-type (use funct)
 o_alu_src_a  out  1  0 PC, 1 register A
 o_alu_src_b  out  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2
 o_pc_write  out  1  unconditional PC load
 o_pc_write_cond  out  1  PC load if ALU zero
 o_pc_source  out  2  00 ALU result, 01 ALU out reg, 10 jump target
 o_i_or_d  out  1  memory address: 0 PC, 1 ALU out
 o_mem_read  out  1  memory read request
 o_mem_write  out  1  memory write request
 o_ir_write  out  1  instruction register load
 o_mem_to_reg  out  1  write-back source: 0 ALU out, 1 memory data
 o_reg_write  out  1  register file write
 o_reg_dst  out  1  destination: 0 rt, 1 rd
 o_state  out  NB_STATE  current state encoding
 o_illegal  out  1  one-cycle pulse on unsupported opcode
 o_inst_count  out  NB_COUNT  retired instructions

Function
REQ-006 States and encodings SHALL be RESET 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, ALUWB 8, BRANCH 9, JUMP 10; codes 11-15 SHALL transition to FETCH.
REQ-007 Transitions: RESET->FETCH when i_enable=1, else hold; FETCH->DECODE when i_mem_ready=1, else hold.
REQ-008 DECODE transitions: opcode 100011 or 101011 ->MEMADR; 000000 ->EXEC; 000100 ->BRANCH; 000010 ->JUMP; any other ->FETCH.
REQ-009 MEMADR SHALL go to MEMRD for 100011 and to MEMWR for 101011, using i_opcode as sampled in MEMADR.
REQ-010 MEMRD->MEMWB and MEMWR->FETCH only when i_mem_ready=1, else hold; MEMWB, ALUWB, BRANCH and JUMP ->FETCH; EXEC->ALUWB.
REQ-011 Control outputs SHALL be decoded from the state, and any signal not listed for a state SHALL be 0:
 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=i_mem_ready
 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00
 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00
 MEMRD: mem_read=1, i_or_d=1
 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0
 MEMWR: mem_write=1, i_or_d=1
 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10
 ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0
 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01
 JUMP: pc_write=1, pc_source=10
REQ-012 o_illegal SHALL be a register set to 1 for exactly the cycle after DECODE sees an unsupported opcode, and 0 otherwise.
REQ-013 o_inst_count SHALL increment by 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH or JUMP, and SHALL wrap from all-ones to 0; illegal opcodes and RESET->FETCH SHALL NOT count.
REQ-014 o_mem_read and o_mem_write SHALL never both be 1.

Reset
REQ-015 When i_rst_n=0, the state SHALL become RESET immediately, independent of i_clk, including mid-instruction; o_inst_count SHALL become 0, o_illegal SHALL become 0, and all control outputs SHALL be 0.
REQ-016 After i_rst_n deasserts, the first FETCH SHALL NOT occur before the first rising edge with i_enable=1.

Verification
REQ-017 Reset, then i_enable=1, i_mem_ready=1, opcode 100011 -> state sequence 1,2,3,4,5,1, reg_write=1 in MEMWB, and count=1.
REQ-018 opcode 000000 -> states 1,2,7,8,1, alu_op=10 in EXEC, reg_dst=1 in ALUWB; opcode 000100 -> 1,2,9,1 with pc_write_cond=1.
REQ-019 opcode 101011 with i_mem_ready low for 3 cycles in MEMWR -> state stays at 6 with mem_write=1 for 4 cycles, then FETCH, and count increments once.
REQ-020 opcode 111111 -> DECODE->FETCH, o_illegal=1 for one cycle, count unchanged.
REQ-021 i_rst_n pulled low during MEMRD -> state 0 and outputs 0 at once; after release with i_enable=0, the FSM holds in RESET.
REQ-022 Preload the count to all-ones via a sequence of instructions, or via a reduced-width NB_COUNT=4 run of 16 jumps (opcode 000010) -> the count wraps to 0.
